// File: rtl/decode_8b10b_multi.sv
// decode_8b10b_multi: SYMS-lane 8b/10b decoder with chained running disparity and comma-based link sync.
// Define DECODE_8B10B_ERR_CNT_EN to build the saturating errored-symbol counter (err_count/clr_count).
module decode_8b10b_multi #(
  parameter int SYMS       = 2,
  parameter int ACQ_COMMAS = 4,
  parameter int LOSS_ERRS  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [10*SYMS-1:0]   in_data,
  output logic                 out_valid,
  output logic [9*SYMS-1:0]    out_data,
  output logic [SYMS-1:0]      out_code_err,
  output logic [SYMS-1:0]      out_disp_err,
  output logic                 rd_out,
  output logic                 sync,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int BW = $clog2(LOSS_ERRS + 1);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_COMMAS - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_ERRS - 1);

  typedef struct packed {
    logic       k;
    logic [7:0] data;
    logic       code_err;
    logic       disp_err;
    logic       rd;
  } lane_t;

  typedef enum logic [1:0] {S_LOS = 2'd0, S_ACQ = 2'd1, S_SYNC = 2'd2} state_t;

  // 6b sub-block (abcdei order, a in MSB) -> {valid, EDCBA}
  function automatic logic [5:0] dec6(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
      default:              dec6 = 6'b000000;
    endcase
  endfunction

  // 4b sub-block (fghj order, f in MSB) -> {valid, HGF}; includes both primary and alternate .7
  function automatic logic [3:0] dec4(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
      4'b1001:                            dec4 = {1'b1, 3'd1};
      4'b0101:                            dec4 = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
      4'b1010:                            dec4 = {1'b1, 3'd5};
      4'b0110:                            dec4 = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:                            dec4 = 4'b0000;
    endcase
  endfunction

  function automatic lane_t dec_sym(input logic [9:0] s, input logic rd_in);
    lane_t      r;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [3:0] c4d;
    logic [5:0] r6;
    logic [3:0] r4;
    logic [4:0] x;
    logic [2:0] n6;
    logic [2:0] n4;
    logic       k28;
    logic       xk7;
    logic       x_a7p;
    logic       x_a7n;
    logic       a7_bad;
    logic       p7_bad;
    logic       rd_mid;
    c6  = {s[0], s[1], s[2], s[3], s[4], s[5]};
    c4  = {s[6], s[7], s[8], s[9]};
    k28 = (c6 == 6'b001111) || (c6 == 6'b110000);
    // K28 on the negative 6b code carries complemented 3b/4b data
    c4d = (c6 == 6'b110000) ? ~c4 : c4;
    r6  = dec6(c6);
    r4  = dec4(c4d);
    x   = r6[4:0];
    xk7   = r6[5] && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
    x_a7p = r6[5] && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14));
    x_a7n = r6[5] && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
    // alternate .7 is only legal where the primary would make a run of five
    a7_bad = ((c4 == 4'b1000) && !(x_a7p || xk7 || (c6 == 6'b001111))) ||
             ((c4 == 4'b0111) && !(x_a7n || xk7 || (c6 == 6'b110000)));
    p7_bad = ((c4 == 4'b1110) && x_a7n) || ((c4 == 4'b0001) && x_a7p);
    r.k        = k28 || (xk7 && ((c4 == 4'b0111) || (c4 == 4'b1000)));
    r.data     = {r4[2:0], x};
    r.code_err = !r6[5] || !r4[3] || a7_bad || p7_bad;
    r.disp_err = 1'b0;
    n6 = 3'($countones(c6));
    n4 = 3'($countones(c4));
    case (n6)
      3'd4: begin r.disp_err = rd_in;  rd_mid = 1'b1; end
      3'd2: begin r.disp_err = !rd_in; rd_mid = 1'b0; end
      3'd3: begin
        rd_mid = rd_in;
        if (c6 == 6'b111000) r.disp_err = rd_in;
        else if (c6 == 6'b000111) r.disp_err = !rd_in;
        else r.disp_err = 1'b0;
      end
      default: rd_mid = (n6 > 3'd3);
    endcase
    case (n4)
      3'd3: begin r.disp_err = r.disp_err | rd_mid;  r.rd = 1'b1; end
      3'd1: begin r.disp_err = r.disp_err | !rd_mid; r.rd = 1'b0; end
      3'd2: begin
        r.rd = rd_mid;
        if (c4 == 4'b1100) r.disp_err = r.disp_err | rd_mid;
        else if (c4 == 4'b0011) r.disp_err = r.disp_err | !rd_mid;
        else r.disp_err = r.disp_err;
      end
      default: r.rd = (n4 > 3'd2);
    endcase
    return r;
  endfunction

  lane_t                 lane [SYMS];
  logic                  rd;
  logic                  rd_next;
  logic [9*SYMS-1:0]     dec_data;
  logic [SYMS-1:0]       code_e;
  logic [SYMS-1:0]       disp_e;
  logic                  err_word;
  logic                  comma_word;
  state_t                state;
  logic [AW-1:0]         acq_cnt;
  logic [BW-1:0]         bad_cnt;

  // decode every lane, threading running disparity from lane 0 upward
  always_comb begin
    logic rd_v;
    rd_v       = rd;
    dec_data   = '0;
    code_e     = '0;
    disp_e     = '0;
    comma_word = 1'b0;
    for (int i = 0; i < SYMS; i++) begin
      lane[i] = dec_sym(in_data[10*i +: 10], rd_v);
      rd_v    = lane[i].rd;
      dec_data[9*i +: 9] = {lane[i].k, lane[i].data};
      code_e[i] = lane[i].code_err;
      disp_e[i] = lane[i].disp_err;
      if (lane[i].k && !lane[i].code_err && !lane[i].disp_err &&
          ((lane[i].data == 8'h3C) || (lane[i].data == 8'hBC) || (lane[i].data == 8'hFC)))
        comma_word = 1'b1;
      else
        comma_word = comma_word;
    end
    rd_next  = rd_v;
    err_word = |(code_e | disp_e);
  end

  assign rd_out = rd;

  // output registers and running disparity; held across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_code_err <= '0;
      out_disp_err <= '0;
      rd           <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data     <= dec_data;
        out_code_err <= code_e;
        out_disp_err <= disp_e;
        rd           <= rd_next;
      end
    end
  end

  // link-sync FSM; the LOS->ACQ comma does not count toward acquisition
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOS;
      acq_cnt <= '0;
      bad_cnt <= '0;
      sync    <= 1'b0;
    end else if (in_valid) begin
      case (state)
        S_LOS: begin
          if (comma_word && !err_word) begin
            state   <= S_ACQ;
            acq_cnt <= '0;
          end
        end
        S_ACQ: begin
          if (err_word) begin
            state   <= S_LOS;
            acq_cnt <= '0;
          end else if (comma_word) begin
            if (acq_cnt == ACQ_LAST) begin
              state   <= S_SYNC;
              acq_cnt <= '0;
              bad_cnt <= '0;
              sync    <= 1'b1;
            end else begin
              acq_cnt <= acq_cnt + AW'(1);
            end
          end
        end
        S_SYNC: begin
          if (err_word) begin
            if (bad_cnt == LOSS_LAST) begin
              state   <= S_LOS;
              bad_cnt <= '0;
              sync    <= 1'b0;
            end else begin
              bad_cnt <= bad_cnt + BW'(1);
            end
          end else begin
            bad_cnt <= '0;
          end
        end
        default: begin
          state   <= S_LOS;
          acq_cnt <= '0;
          bad_cnt <= '0;
          sync    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODE_8B10B_ERR_CNT_EN
  logic [CNT_W:0] cnt_sum;

  // saturating accumulate of errored lanes in each valid word
  always_comb begin
    cnt_sum = {1'b0, err_count} + (CNT_W+1)'($countones(code_e | disp_e));
  end

  // clear has priority over accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (in_valid) begin
      err_count <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_count;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_decode_8b10b_multi.sv
// Directed bench for decode_8b10b_multi (SYMS=2); symbols are written in abcdeifghj order and bit-reversed onto the lane.
module tb_decode_8b10b_multi;
  localparam int SYMS = 2;
`ifdef DECODE_8B10B_ERR_CNT_EN
  localparam int CNT_W = 4;
  localparam bit CNT_EN = 1'b1;
`else
  localparam int CNT_W = 16;
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [10*SYMS-1:0]   in_data;
  logic                 out_valid;
  logic [9*SYMS-1:0]    out_data;
  logic [SYMS-1:0]      out_code_err;
  logic [SYMS-1:0]      out_disp_err;
  logic                 rd_out;
  logic                 sync;
  logic                 clr_count;
  logic [CNT_W-1:0]     err_count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_8b10b_multi #(.SYMS(SYMS), .ACQ_COMMAS(4), .LOSS_ERRS(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_code_err(out_code_err),
    .out_disp_err(out_disp_err), .rd_out(rd_out), .sync(sync),
    .clr_count(clr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // abcdeifghj string (a = MSB) -> lane layout (a = bit 0)
  function automatic logic [9:0] sym(input logic [9:0] s);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = s[9-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [9:0] l1, input logic [9:0] l0);
    in_valid = v;
    in_data  = {l1, l0};
    @(posedge clk);
    #1;
  endtask

  logic [9:0] d21_5, d10_2, kp, kn, k28_7n, bad;
  logic       exp_rd;

  initial begin
    d21_5  = sym(10'b1010101010);
    d10_2  = sym(10'b0101010101);
    kn     = sym(10'b0011111010);
    kp     = sym(10'b1100000101);
    k28_7n = sym(10'b0011111000);
    bad    = 10'b0000000000;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_count = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_cerr", 32'(out_code_err), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    rst = 1'b0;

    // basic decode with RD chaining inside and across words
    step(1'b1, kn, d21_5);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data", 32'(out_data), 32'({9'h1BC, 9'h0B5}));
    check("w1_errs", 32'({out_code_err, out_disp_err}), 32'd0);
    check("w1_rd", 32'(rd_out), 32'd1);
    step(1'b1, kp, d10_2);
    check("w2_data", 32'(out_data), 32'({9'h1BC, 9'h04A}));
    check("w2_errs", 32'({out_code_err, out_disp_err}), 32'd0);
    check("w2_rd", 32'(rd_out), 32'd0);
    step(1'b1, d10_2, k28_7n);
    check("w3_data", 32'(out_data), 32'({9'h04A, 9'h1FC}));
    check("w3_errs", 32'({out_code_err, out_disp_err}), 32'd0);
    check("w3_rd", 32'(rd_out), 32'd0);

    // idle cycles: out_valid drops, data and rd hold
    step(1'b0, bad, bad);
    check("idle0_valid", 32'(out_valid), 32'd0);
    check("idle0_data", 32'(out_data), 32'({9'h04A, 9'h1FC}));
    step(1'b1, kn, d21_5);
    check("tog1_valid", 32'(out_valid), 32'd1);
    check("tog1_rd", 32'(rd_out), 32'd1);
    step(1'b0, bad, bad);
    check("tog2_valid", 32'(out_valid), 32'd0);
    check("tog2_rd", 32'(rd_out), 32'd1);
    step(1'b1, kp, d21_5);
    check("tog3_valid", 32'(out_valid), 32'd1);
    check("tog3_rd", 32'(rd_out), 32'd0);
    check("tog3_errs", 32'({out_code_err, out_disp_err}), 32'd0);

    // reset mid-stream discards the in-flight word
    rst = 1'b1;
    step(1'b1, kn, d21_5);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_rd", 32'(rd_out), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // acquisition: sync rises with the 5th clean comma word
    exp_rd = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, exp_rd ? kp : kn, d21_5);
      exp_rd = ~exp_rd;
      check($sformatf("acq%0d_sync", k), 32'(sync), (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("acq%0d_rd", k), 32'(rd_out), 32'(exp_rd));
    end

    // loss of sync: clean word resets bad count, third consecutive error drops
    step(1'b1, d21_5, bad);
    check("los1_cerr", 32'(out_code_err), 32'd1);
    check("los1_sync", 32'(sync), 32'd1);
    step(1'b1, d21_5, bad);
    check("los2_sync", 32'(sync), 32'd1);
    step(1'b1, kn, d21_5);
    check("los3_sync", 32'(sync), 32'd1);
    check("los3_rd", 32'(rd_out), 32'd1);
    step(1'b1, d21_5, bad);
    check("los4_sync", 32'(sync), 32'd1);
    check("los4_rd", 32'(rd_out), 32'd0);
    step(1'b1, d21_5, bad);
    check("los5_sync", 32'(sync), 32'd1);
    step(1'b1, d21_5, bad);
    check("los6_sync", 32'(sync), 32'd0);

    // K28.5 RD+ code presented at negative RD
    step(1'b1, d21_5, kp);
    check("derr_cerr", 32'(out_code_err), 32'd0);
    check("derr_derr", 32'(out_disp_err), 32'd1);
    check("derr_data", 32'(out_data), 32'({9'h0B5, 9'h1BC}));
    check("derr_rd", 32'(rd_out), 32'd0);

    // error counter: two errored lanes per word, saturation and clear priority
    rst = 1'b1;
    step(1'b0, bad, bad);
    rst = 1'b0;
    step(1'b1, bad, bad);
    check("cnt_first", 32'(err_count), CNT_EN ? 32'd2 : 32'd0);
    for (int k = 0; k < 9; k++) step(1'b1, bad, bad);
    check("cnt_sat", 32'(err_count), CNT_EN ? 32'd15 : 32'd0);
    clr_count = 1'b1;
    step(1'b1, bad, bad);
    clr_count = 1'b0;
    check("cnt_clr", 32'(err_count), 32'd0);
    step(1'b1, bad, d21_5);
    check("cnt_after", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
